// File: rtl/exec_stage_pipe.sv
// Execute stage: ALU, shifter pass-through and iterative shift-add multiplier feeding
// one result register, with a valid/ready handshake that stalls while a multiply runs.
module exec_stage_pipe #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] ALUInA,
   input  logic [WIDTH-1:0] ALUInB,
   input  logic [3:0]       ALUop,
   input  logic [WIDTH-1:0] ShifterOut,
   input  logic [1:0]       ResSource,
   input  logic             ResWrite,
   output logic [WIDTH-1:0] ResOut,
   output logic             isZero,
   output logic             OutValid,
   output logic             Busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
   logic [CW-1:0]    cnt;
   logic             wr_q;
   logic [WIDTH-1:0] alu_res, sel_res;
   logic             accept, start_mul, mul_done;

   assign accept    = InValid && InReady;
   assign start_mul = MUL_EN && accept && (ResSource == 2'd2);
   assign mul_done  = (state == MUL) && (cnt == CNT_LAST);

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state logic
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_mul) state_n = MUL;
         MUL:     if (mul_done)  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      InReady = (state == IDLE);
      Busy    = (state == MUL);
   end

   always_comb begin
      alu_res = ALUInA;
      case (ALUop)
         4'd0: alu_res = ALUInA + ALUInB;
         4'd1: alu_res = ALUInA - ALUInB;
         4'd2: alu_res = ALUInA & ALUInB;
         4'd3: alu_res = ALUInA | ALUInB;
         4'd4: alu_res = ALUInA ^ ALUInB;
         4'd5: alu_res = ~(ALUInA | ALUInB);
         4'd6: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ALUInA) < $signed(ALUInB))};
         4'd7: alu_res = {{(WIDTH-1){1'b0}}, (ALUInA < ALUInB)};
         default: alu_res = ALUInA;
      endcase
   end

   // With MUL_EN=0, source 2 falls through to the ALU result.
   always_comb begin
      sel_res = alu_res;
      if (ResSource == 2'd1) sel_res = ShifterOut;
   end

   // One partial product per cycle; bit cnt of A gates B shifted by cnt.
   always_comb begin
      acc_next = acc;
      if (a_q[cnt]) acc_next = acc + (b_q << cnt);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         ResOut   <= '0;
         isZero   <= 1'b1;
         OutValid <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         cnt      <= '0;
         wr_q     <= 1'b0;
      end else begin
         OutValid <= 1'b0;
         if (start_mul) begin
            a_q  <= ALUInA;
            b_q  <= ALUInB;
            wr_q <= ResWrite;
            acc  <= '0;
            cnt  <= '0;
         end else if (accept) begin
            OutValid <= 1'b1;
            if (ResWrite && ResSource != 2'd3) begin
               ResOut <= sel_res;
               isZero <= (sel_res == '0);
            end
         end else if (state == MUL) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (mul_done) begin
               OutValid <= 1'b1;
               cnt      <= '0;
               if (wr_q) begin
                  ResOut <= acc_next;
                  isZero <= (acc_next == '0);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed-vector bench for exec_stage_pipe at WIDTH=16 with hand-computed expectations.
module tb_exec_stage_pipe;

   logic        CLK = 1'b0;
   logic        Reset, InValid, InReady, ResWrite;
   logic [15:0] ALUInA, ALUInB, ShifterOut, ResOut;
   logic [3:0]  ALUop;
   logic [1:0]  ResSource;
   logic        isZero, OutValid, Busy;

   int vectors     = 0;
   int miscompares = 0;

   exec_stage_pipe #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .ALUInA(ALUInA), .ALUInB(ALUInB), .ALUop(ALUop), .ShifterOut(ShifterOut),
      .ResSource(ResSource), .ResWrite(ResWrite), .ResOut(ResOut),
      .isZero(isZero), .OutValid(OutValid), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; outputs are then stable for checking.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] src, input logic wr);
      InValid = 1'b1; ALUop = op; ALUInA = a; ALUInB = b; ResSource = src; ResWrite = wr;
      step();
      InValid = 1'b0;
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
      issue(op, a, b, 2'd0, 1'b1);
      check({tag, "_res"}, ResOut, exp);
      check({tag, "_ov"}, OutValid, 1'b1);
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; ALUInA = '0; ALUInB = '0; ALUop = '0;
      ShifterOut = '0; ResSource = '0; ResWrite = 1'b0;
      step(); step();
      Reset = 1'b0;
      check("rst_res", ResOut, 16'h0000);
      check("rst_zero", isZero, 1'b1);
      check("rst_ov", OutValid, 1'b0);
      check("rst_rdy", InReady, 1'b1);
      check("rst_busy", Busy, 1'b0);

      // ADD wraps into the sign bit
      issue(4'd0, 16'h7FFF, 16'h0001, 2'd0, 1'b1);
      check("add_res", ResOut, 16'h8000);
      check("add_zero", isZero, 1'b0);
      check("add_ov", OutValid, 1'b1);
      step();
      check("add_ov_pulse", OutValid, 1'b0);

      // SUB to zero, then shifter result accepted on the very next edge
      InValid = 1'b1; ALUop = 4'd1; ALUInA = 16'h1234; ALUInB = 16'h1234;
      ResSource = 2'd0; ResWrite = 1'b1;
      step();
      check("sub_res", ResOut, 16'h0000);
      check("sub_zero", isZero, 1'b1);
      check("sub_ov", OutValid, 1'b1);
      ResSource = 2'd1; ShifterOut = 16'h00F0;
      step();
      InValid = 1'b0;
      check("shf_res", ResOut, 16'h00F0);
      check("shf_zero", isZero, 1'b0);
      check("shf_ov", OutValid, 1'b1);
      step();
      check("shf_ov_pulse", OutValid, 1'b0);

      // MUL 3 * FFFF with operands disturbed while iterating
      issue(4'd0, 16'h0003, 16'hFFFF, 2'd2, 1'b1);
      check("mul_rdy_e", InReady, 1'b0);
      check("mul_busy_e", Busy, 1'b1);
      check("mul_hold", ResOut, 16'h00F0);
      ALUInA = 16'h0005; ALUInB = 16'h0007;
      for (int i = 1; i < 16; i++) begin
         step();
         check($sformatf("mul_rdy_%0d", i), InReady, 1'b0);
         check($sformatf("mul_ov_%0d", i), OutValid, 1'b0);
      end
      step();
      check("mul_res", ResOut, 16'hFFFD);
      check("mul_zero", isZero, 1'b0);
      check("mul_ov", OutValid, 1'b1);
      check("mul_rdy_done", InReady, 1'b1);
      step();
      check("mul_ov_pulse", OutValid, 1'b0);

      // Reset during iteration 8 aborts the multiply silently
      issue(4'd0, 16'h0003, 16'h0005, 2'd2, 1'b1);
      for (int i = 0; i < 8; i++) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("abort_res", ResOut, 16'h0000);
      check("abort_zero", isZero, 1'b1);
      check("abort_ov", OutValid, 1'b0);
      check("abort_rdy", InReady, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("abort_quiet_%0d", i), OutValid, 1'b0);
      end

      // SLT without write leaves ResOut alone; SLTU with write lands zero
      alu_vec("seed", 4'd0, 16'h00AA, 16'h0000, 16'h00AA);
      issue(4'd6, 16'h8000, 16'h0001, 2'd0, 1'b0);
      check("slt_ov", OutValid, 1'b1);
      check("slt_hold", ResOut, 16'h00AA);
      check("slt_zero", isZero, 1'b0);
      issue(4'd7, 16'h8000, 16'h0001, 2'd0, 1'b1);
      check("sltu_res", ResOut, 16'h0000);
      check("sltu_zero", isZero, 1'b1);

      // Remaining ALU ops
      alu_vec("sub_wrap", 4'd1, 16'h0000, 16'h0001, 16'hFFFF);
      alu_vec("and", 4'd2, 16'hF0F0, 16'hFF00, 16'hF000);
      alu_vec("or", 4'd3, 16'hF0F0, 16'hFF00, 16'hFFF0);
      alu_vec("xor", 4'd4, 16'hF0F0, 16'hFF00, 16'h0FF0);
      alu_vec("nor", 4'd5, 16'hF0F0, 16'hFF00, 16'h000F);
      alu_vec("slt_neg", 4'd6, 16'hF0F0, 16'hFF00, 16'h0001);
      alu_vec("sltu_big", 4'd7, 16'hFF00, 16'hF0F0, 16'h0000);
      alu_vec("pass_a", 4'd9, 16'hF0F0, 16'hFF00, 16'hF0F0);

      // Source 3 is a no-op that still completes
      issue(4'd0, 16'h1111, 16'h2222, 2'd3, 1'b1);
      check("nop_ov", OutValid, 1'b1);
      check("nop_hold", ResOut, 16'hF0F0);
      check("nop_zero", isZero, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
